// File: rtl/lr_pkg.sv
// Shared types and default sizing for the linear-regression datapath.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the sample-loader state encoding and the default element width,
// dataset size and input range used by the loader and downstream stages.
package lr_pkg;

  localparam int LR_ELEM_WIDTH  = 14;
  localparam int LR_NUM_SAMPLES = 3;
  localparam int LR_MAX_VALUE   = 99;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FULL    = 2'd1,
    ERR     = 2'd2
  } loader_state_t;

endpackage

// File: rtl/rising_edge_det.sv
// Rising-edge detector for a level input (debounced button or mode line).
// Latency: pulse is combinational from sig against the previous-cycle level.
// Backpressure: none; one pulse per low-to-high transition.
//
// Ports: clk, rst (sync, active-high), sig (level in), pulse (edge out).
// prev resets to 1 so a level already high when reset releases is not an edge.
module rising_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic pulse
);

  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev <= 1'b1;
    end else begin
      prev <= sig;
    end
  end

  assign pulse = sig & ~prev;

endmodule

// File: rtl/sample_loader.sv
// Collects NUM_SAMPLES (x, y) pairs from data_in, builds X (with bias column) and y.
// Latency: a value captured on an edge in cycle N appears on x_data/y_data in N+1.
// Backpressure: none; enter edges outside COLLECT are dropped, ready holds until done.
//
// Ports: clk, rst (sync, active-high); enter, input_done (button levels);
// data_in (value to capture); x_data, y_data (assembled dataset); ready,
// valid_pulse, error (status); sample_count, expect_y (entry progress).
module sample_loader
  import lr_pkg::*;
#(
  parameter int ELEM_WIDTH  = LR_ELEM_WIDTH,
  parameter int NUM_SAMPLES = LR_NUM_SAMPLES,
  parameter int MAX_VALUE   = LR_MAX_VALUE
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  enter,
  input  logic                                  input_done,
  input  logic [ELEM_WIDTH-1:0]                 data_in,
  output logic [NUM_SAMPLES*2*ELEM_WIDTH-1:0]   x_data,
  output logic [NUM_SAMPLES*ELEM_WIDTH-1:0]     y_data,
  output logic                                  ready,
  output logic                                  valid_pulse,
  output logic                                  error,
  output logic [$clog2(NUM_SAMPLES+1)-1:0]      sample_count,
  output logic                                  expect_y
);

  localparam int CW = $clog2(NUM_SAMPLES+1);

  logic enter_edge;
  logic done_edge;

  rising_edge_det u_enter_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (enter),
    .pulse (enter_edge)
  );

  rising_edge_det u_done_det (
    .clk   (clk),
    .rst   (rst),
    .sig   (input_done),
    .pulse (done_edge)
  );

  loader_state_t                             state_q, state_n;
  logic [NUM_SAMPLES-1:0][ELEM_WIDTH-1:0]    x_q, x_n;
  logic [NUM_SAMPLES-1:0][ELEM_WIDTH-1:0]    y_q, y_n;
  logic [CW-1:0]                             count_q, count_n;
  logic [CW-1:0]                             count_inc;
  logic                                      expy_q, expy_n;
  logic                                      ready_q, ready_n;
  logic                                      error_q, error_n;
  logic                                      vp_q, vp_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      x_q     <= '0;
      y_q     <= '0;
      count_q <= '0;
      expy_q  <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
      vp_q    <= 1'b0;
    end else begin
      state_q <= state_n;
      x_q     <= x_n;
      y_q     <= y_n;
      count_q <= count_n;
      expy_q  <= expy_n;
      ready_q <= ready_n;
      error_q <= error_n;
      vp_q    <= vp_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    x_n       = x_q;
    y_n       = y_q;
    count_n   = count_q;
    expy_n    = expy_q;
    count_inc = count_q + 1'b1;

    case (state_q)
      COLLECT: begin
        // A done edge wins over a same-cycle enter edge; finishing early
        // (including with nothing entered) is an incomplete dataset.
        if (done_edge) begin
          state_n = ERR;
        end else if (enter_edge) begin
          if (data_in > ELEM_WIDTH'(MAX_VALUE)) begin
            state_n = ERR;
          end else if (!expy_q) begin
            for (int r = 0; r < NUM_SAMPLES; r++) begin
              if (count_q == CW'(r)) x_n[r] = data_in;
            end
            expy_n = 1'b1;
          end else begin
            for (int r = 0; r < NUM_SAMPLES; r++) begin
              if (count_q == CW'(r)) y_n[r] = data_in;
            end
            expy_n  = 1'b0;
            count_n = count_inc;
            if (count_inc == CW'(NUM_SAMPLES)) state_n = FULL;
          end
        end
      end
      FULL, ERR: begin
        // Buffers stay frozen; only a done edge restarts entry from scratch.
        if (done_edge) begin
          state_n = COLLECT;
          x_n     = '0;
          y_n     = '0;
          count_n = '0;
          expy_n  = 1'b0;
        end
      end
      default: begin
        state_n = COLLECT;
      end
    endcase

    // Status flags are computed from the next state so they register
    // alongside the data they describe.
    ready_n = (state_n == FULL);
    error_n = (state_n == ERR);
    vp_n    = (state_n == FULL) && (state_q != FULL);
  end

  // Bias column is a constant 1 and never stored.
  for (genvar r = 0; r < NUM_SAMPLES; r++) begin : g_rows
    assign x_data[(r*2)*ELEM_WIDTH +: ELEM_WIDTH]   = x_q[r];
    assign x_data[(r*2+1)*ELEM_WIDTH +: ELEM_WIDTH] = ELEM_WIDTH'(1);
    assign y_data[r*ELEM_WIDTH +: ELEM_WIDTH]       = y_q[r];
  end

  assign ready        = ready_q;
  assign valid_pulse  = vp_q;
  assign error        = error_q;
  assign sample_count = count_q;
  assign expect_y     = expy_q;

endmodule

// File: doc/sample_loader.md
Name: sample_loader

Overview:
- Upstream front-end of the linear-regression datapath; replaces the hard-coded sample source.
- Serially collects NUM_SAMPLES (x, y) pairs from a shared data_in bus, one value per enter press.
- Assembles the design matrix X (one row per sample, with a constant-1 bias column) and the y vector.
- Raises ready, plus a one-cycle valid_pulse, to start the transpose/multiply chain.

Parameters:
- ELEM_WIDTH, 14, width of each matrix element and of data_in.
- NUM_SAMPLES, 3, number of (x, y) pairs per dataset.
- MAX_VALUE, 99, largest accepted data_in value (unsigned); the display path is two decimal digits.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- enter  input  1  level from debounced button; each rising edge submits data_in.
- input_done  input  1  level; a rising edge finishes entry or restarts.
- data_in  input  ELEM_WIDTH  unsigned value to capture.
- x_data  output  NUM_SAMPLES*2*ELEM_WIDTH  X matrix, row-major; element (r,c) at bits [(r*2+c)*ELEM_WIDTH +: ELEM_WIDTH]; c=0 is x_r, c=1 is the constant 1.
- y_data  output  NUM_SAMPLES*ELEM_WIDTH  y_r at bits [r*ELEM_WIDTH +: ELEM_WIDTH].
- ready  output  1  level; dataset complete and stable.
- valid_pulse  output  1  one-cycle strobe on entry to FULL.
- error  output  1  level; held while in ERR.
- sample_count  output  $clog2(NUM_SAMPLES+1)  number of completed pairs.
- expect_y  output  1  0 = next value is x, 1 = next value is y.

Behaviour:
- Edge detection
  - enter_prev and done_prev are registered.
  - A rising edge is sig & ~prev.
  - Both prev registers reset to 1, so a button held through reset produces no event.
- Event priority: a done edge outranks an enter edge in the same cycle; that enter edge is dropped.
- States: COLLECT, FULL, ERR.
- Reset (sync)
  - state=COLLECT; x_data has all x fields 0 and all bias fields 1; y_data=0.
  - sample_count=0, expect_y=0, ready=0, valid_pulse=0, error=0.
- COLLECT, enter edge with data_in > MAX_VALUE: go to ERR; nothing stored.
- COLLECT, enter edge with expect_y=0:
  - x field of row sample_count <= data_in.
  - expect_y <= 1.
- COLLECT, enter edge with expect_y=1:
  - y field of row sample_count <= data_in.
  - expect_y <= 0; sample_count++.
  - If the new count == NUM_SAMPLES: go to FULL.
- COLLECT, done edge: go to ERR (incomplete dataset); this includes a done edge with count 0.
- FULL
  - ready=1; valid_pulse=1 only on the first cycle in FULL.
  - x_data and y_data are frozen; enter edges are ignored.
  - done edge: clear buffers to their reset values, count=0, expect_y=0, go to COLLECT.
- ERR
  - error=1; enter edges are ignored; buffers keep their last contents.
  - done edge: clear buffers and go to COLLECT, exactly as from FULL.
- Latency
  - A value captured by an edge detected in cycle N is visible on x_data/y_data in cycle N+1.
  - ready and valid_pulse assert in cycle N+1 after the final y edge.
- All outputs are registered; no combinational path from inputs to outputs.
- rst asserted in any state, including mid-entry, returns everything to reset values on the next clk edge; partial data is discarded.
- The bias field is always driven to 1 (zero-extended to ELEM_WIDTH) and is never writable.

Decomposition:
- Shared package lr_pkg holds:
  - enum loader_state_t {COLLECT, FULL, ERR};
  - default ELEM_WIDTH, NUM_SAMPLES, MAX_VALUE constants, also used by the transpose/multiply/inverse stages.
- One sub-module, rising_edge_det (clk, rst, sig, pulse), instantiated twice. Its reset value of prev is 1.

Test Plan:
- Normal load: enter 2,3,5,6,8,9 as isolated one-cycle pulses.
  - Row 0 = (2,1), row 1 = (5,1), row 2 = (8,1); y = 3,6,9.
  - ready=1 one cycle after the last enter; valid_pulse high exactly one cycle; sample_count=3.
- Held button: enter held high 5 cycles with data_in=7, then released.
  - Only row 0 x=7 captured; expect_y=1; sample_count=0.
- Over-range: after 4 then 6, enter data_in=100.
  - error=1; row 1 x stays 0; further enters ignored.
  - A done edge then returns to COLLECT with count=0, error=0.
- Early done: after one pair (1,2), a done edge gives error=1, ready=0.
  - A second done edge restarts with buffers cleared and bias fields still 1.
- Simultaneous: in FULL, enter and input_done rise in the same cycle.
  - Buffers cleared, COLLECT entered, enter edge dropped; x row 0 remains 0.
- Reset mid-entry: rst asserted after 3 values entered.
  - Next cycle: all outputs at reset values.
  - With enter held high through reset release, no capture occurs.
